// File: rtl/regs_wb_arbiter_if.sv
// Writeback request/grant bundle between the writeback sources and the
// register-file write port arbiter.
interface regs_wb_arbiter_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NR_REQ     = 2
);
    localparam int GID_W = $clog2(NR_REQ);

    logic                         hold;
    logic [NR_REQ-1:0]            req_valid;
    logic [NR_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NR_REQ*WIDTH-1:0]      req_data;
    logic [NR_REQ-1:0]            req_ready;
    logic                         wen;
    logic [ADDR_WIDTH-1:0]        addrw;
    logic [WIDTH-1:0]             dinw;
    logic [GID_W-1:0]             grant_id;

    // Requester side plus the write-port hold control.
    modport master (
        output hold, req_valid, req_addr, req_data,
        input  req_ready, wen, addrw, dinw, grant_id
    );

    // Arbiter side.
    modport slave (
        input  hold, req_valid, req_addr, req_data,
        output req_ready, wen, addrw, dinw, grant_id
    );
endinterface

// File: rtl/regs_wb_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among
// NR_REQ writeback requesters; the accepted write is registered for one cycle.
module regs_wb_arbiter #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NR_REQ     = 2
) (
    input  logic               clk,
    input  logic               rst,
    regs_wb_arbiter_if.slave   wb
);
    localparam int               GID_W    = $clog2(NR_REQ);
    localparam logic [GID_W:0]   NR_REQ_W = (GID_W+1)'(NR_REQ);
    localparam logic [GID_W-1:0] LAST_ID  = GID_W'(NR_REQ - 1);

    logic [GID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [GID_W-1:0]      grant_id_q, grant_id_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] addrw_q, addrw_d;
    logic [WIDTH-1:0]      dinw_q, dinw_d;

    logic                  found;
    logic [GID_W-1:0]      win;
    logic [GID_W:0]        idx;
    logic [NR_REQ-1:0]     ready;
    logic                  xfer;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [WIDTH-1:0]      win_data;

    // Scan requesters starting at rr_ptr, wrapping modulo NR_REQ; first valid wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NR_REQ; k++) begin
            idx = {1'b0, rr_ptr_q} + (GID_W+1)'(k);
            if (idx >= NR_REQ_W) idx = idx - NR_REQ_W;
            if (!found && wb.req_valid[idx[GID_W-1:0]]) begin
                found = 1'b1;
                win   = idx[GID_W-1:0];
            end
        end
    end

    // One-hot accept for the winner; suppressed by hold and while in reset.
    always_comb begin
        ready = '0;
        if (rst && !wb.hold && found) ready[win] = 1'b1;
    end

    assign xfer     = |ready;
    assign win_addr = wb.req_addr[ADDR_WIDTH*win +: ADDR_WIDTH];
    assign win_data = wb.req_data[WIDTH*win +: WIDTH];

    // Next-state: capture the accepted write; x0 writes are consumed without wen.
    always_comb begin
        wen_d      = 1'b0;
        addrw_d    = addrw_q;
        dinw_d     = dinw_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        if (xfer) begin
            wen_d      = (win_addr != '0);
            addrw_d    = win_addr;
            dinw_d     = win_data;
            grant_id_d = win;
            rr_ptr_d   = (win == LAST_ID) ? '0 : win + 1'b1;
        end
    end

    // Output register and round-robin pointer; async reset drops any pending write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wen_q      <= 1'b0;
            addrw_q    <= '0;
            dinw_q     <= '0;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            wen_q      <= wen_d;
            addrw_q    <= addrw_d;
            dinw_q     <= dinw_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign wb.req_ready = ready;
    assign wb.wen       = wen_q;
    assign wb.addrw     = addrw_q;
    assign wb.dinw      = dinw_q;
    assign wb.grant_id  = grant_id_q;
endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Testbench for regs_wb_arbiter: directed scenarios with literal expectations
// plus a behavioural model checked against the DUT on every active cycle.
module tb_regs_wb_arbiter;
    localparam int W  = 32;
    localparam int AW = 5;
    localparam int N  = 2;
    localparam int GW = $clog2(N);

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    regs_wb_arbiter_if #(.WIDTH(W), .ADDR_WIDTH(AW), .NR_REQ(N)) bus ();

    regs_wb_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW), .NR_REQ(N)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Round-robin rule: first valid requester at or after ptr, modulo N.
    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++)
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    // Behavioural model state.
    int            m_ptr;
    int            m_pick;
    logic          m_wen;
    logic [AW-1:0] m_addr;
    logic [W-1:0]  m_data;
    logic [GW-1:0] m_gid;
    logic [N-1:0]  c_exp;

    assign m_pick = pick(bus.req_valid, m_ptr);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ptr  <= 0;
            m_wen  <= 1'b0;
            m_addr <= '0;
            m_data <= '0;
            m_gid  <= '0;
        end else if (!bus.hold && m_pick >= 0) begin
            m_wen  <= (bus.req_addr[m_pick*AW +: AW] != '0);
            m_addr <= bus.req_addr[m_pick*AW +: AW];
            m_data <= bus.req_data[m_pick*W +: W];
            m_gid  <= GW'(m_pick);
            m_ptr  <= (m_pick + 1) % N;
        end else begin
            m_wen  <= 1'b0;
        end
    end

    // Register file as the write port would update it.
    logic [W-1:0] rf [0:(1<<AW)-1];
    always @(negedge clk) if (rst && bus.wen) rf[bus.addrw] <= bus.dinw;

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst) begin
            c_exp = '0;
            if (!bus.hold && m_pick >= 0) c_exp[m_pick] = 1'b1;
            chk("m_ready", bus.req_ready, c_exp);
            chk("m_wen",   bus.wen,       m_wen);
            chk("m_addrw", bus.addrw,     m_addr);
            chk("m_dinw",  bus.dinw,      m_data);
            chk("m_gid",   bus.grant_id,  m_gid);
        end
    end

    task automatic drv(input logic [N-1:0] v, input logic [AW-1:0] a0, input logic [W-1:0] d0,
                       input logic [AW-1:0] a1, input logic [W-1:0] d1);
        bus.req_valid = v;
        bus.req_addr  = {a1, a0};
        bus.req_data  = {d1, d0};
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.hold = 1'b0;
        drv(2'b11, 5'd3, 32'hA0, 5'd7, 32'hB1);

        // Reset with all requesters valid.
        #2;
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_wen",   bus.wen, 0);
        chk("rst_addrw", bus.addrw, 0);
        chk("rst_dinw",  bus.dinw, 0);
        chk("rst_gid",   bus.grant_id, 0);
        nxt();
        nxt();
        rst = 1'b1;

        // Both valid continuously: grants alternate 0,1,0,1.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_ready", bus.req_ready, (i % 2 == 0) ? 1 : 2);
            if (i > 0) begin
                chk("t2_wen", bus.wen, 1);
                chk("t2_gid", bus.grant_id, (i - 1) % 2);
                chk("t2_addrw", bus.addrw, ((i - 1) % 2 == 0) ? 3 : 7);
            end else begin
                chk("t2_wen0", bus.wen, 0);
            end
            nxt();
        end
        drv(2'b00, 5'd3, 32'hA0, 5'd7, 32'hB1);
        @(negedge clk);
        chk("t2_last_wen",  bus.wen, 1);
        chk("t2_last_gid",  bus.grant_id, 1);
        chk("t2_last_dinw", bus.dinw, 32'hB1);

        // Write to x0 is consumed without wen; pointer still advances.
        nxt();
        drv(2'b01, 5'd0, 32'hDEADBEEF, 5'd0, 32'h0);
        @(negedge clk);
        chk("t3_ready", bus.req_ready, 1);
        nxt();
        drv(2'b11, 5'd1, 32'h101, 5'd2, 32'h202);
        @(negedge clk);
        chk("t3_wen",   bus.wen, 0);
        chk("t3_gid",   bus.grant_id, 0);
        chk("t3_dinw",  bus.dinw, 32'hDEADBEEF);
        chk("t3_ptr",   bus.req_ready, 2);
        nxt();
        drv(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        @(negedge clk);
        chk("t3_wen1",  bus.wen, 1);
        chk("t3_addrw", bus.addrw, 2);

        // Same address from both requesters: acceptance order is write order.
        nxt();
        drv(2'b11, 5'd5, 32'h11, 5'd5, 32'h22);
        @(negedge clk);
        chk("t4_ready0", bus.req_ready, 1);
        nxt();
        drv(2'b10, 5'd5, 32'h11, 5'd5, 32'h22);
        @(negedge clk);
        chk("t4_ready1", bus.req_ready, 2);
        chk("t4_wen_a",  bus.wen, 1);
        chk("t4_dinw_a", bus.dinw, 32'h11);
        nxt();
        drv(2'b00, 5'd5, 32'h11, 5'd5, 32'h22);
        @(negedge clk);
        chk("t4_wen_b",  bus.wen, 1);
        chk("t4_dinw_b", bus.dinw, 32'h22);
        nxt();
        @(negedge clk);
        chk("t4_wen_off", bus.wen, 0);
        chk("t4_rf5", rf[5], 32'h22);

        // Hold blocks acceptance for three cycles.
        nxt();
        bus.hold = 1'b1;
        drv(2'b10, 5'd0, 32'h0, 5'd9, 32'h55);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_hold_ready", bus.req_ready, 0);
            chk("t5_hold_wen",   bus.wen, 0);
            nxt();
        end
        bus.hold = 1'b0;
        @(negedge clk);
        chk("t5_ready", bus.req_ready, 2);
        nxt();
        drv(2'b00, 5'd0, 32'h0, 5'd9, 32'h55);
        @(negedge clk);
        chk("t5_wen",   bus.wen, 1);
        chk("t5_addrw", bus.addrw, 9);
        chk("t5_gid",   bus.grant_id, 1);
        chk("t5_dinw",  bus.dinw, 32'h55);

        // Reset right after an acceptance discards the pending write.
        nxt();
        drv(2'b11, 5'd4, 32'h66, 5'd6, 32'h77);
        @(negedge clk);
        chk("t6_ready", bus.req_ready, 1);
        nxt();
        chk("t6_wen_pre", bus.wen, 1);
        rst = 1'b0;
        #1;
        chk("t6_wen_rst",   bus.wen, 0);
        chk("t6_ready_rst", bus.req_ready, 0);
        chk("t6_addrw_rst", bus.addrw, 0);
        nxt();
        nxt();
        rst = 1'b1;
        @(negedge clk);
        chk("t6_ready_post", bus.req_ready, 1);
        nxt();
        drv(2'b00, 5'd4, 32'h66, 5'd6, 32'h77);
        @(negedge clk);
        chk("t6_wen_post", bus.wen, 1);
        chk("t6_gid_post", bus.grant_id, 0);
        chk("t6_addrw_post", bus.addrw, 4);
        nxt();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
